bounce_counter_cfg: RTL and testbench

Parametrised up/down sequence generator, successor to the fixed 4-bit 0→15→0 bouncing counter. Adds these features:
- Generic width.
- Runtime lower/upper limits.
- Four modes: bounce, wrap-up, wrap-down, hold.
- Count enable and synchronous load.
- Direction, endpoint-turn and configuration-error outputs.

Used as a pattern/address sweeper and as a stimulus source for display and PWM blocks.

---
 rtl/bounce_counter_cfg.sv | 121 ++++++++++++
 tb/tb_bounce_counter_cfg.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_counter_cfg.sv
// Configurable up/down sequence generator: bounce, wrap-up, wrap-down or hold
// between runtime limits lo..hi, with enable, synchronous load and turn pulse.
module bounce_counter_cfg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             turn,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    MODE_BOUNCE    = 2'b00,
    MODE_WRAP_UP   = 2'b01,
    MODE_WRAP_DOWN = 2'b10,
    MODE_HOLD      = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             turn_q, turn_d;
  logic             in_range;
  logic             load_ok;
  logic             at_hi;
  logic             at_lo;
  mode_e            mode_sel;

  assign cfg_err  = (lo >= hi);
  assign in_range = (count_q >= lo) && (count_q <= hi);
  assign load_ok  = (load_val >= lo) && (load_val <= hi);
  assign at_hi    = (count_q == hi);
  assign at_lo    = (count_q == lo);
  assign mode_sel = mode_e'(mode);

  // Priority: load, then config error, then out-of-range resync, then step.
  // Every +1/-1 below is only taken strictly inside lo..hi, so no wrap occurs.
  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    turn_d  = 1'b0;
    if (load) begin
      count_d = load_ok ? load_val : lo;
    end else if (en) begin
      if (cfg_err || !in_range) begin
        count_d = lo;
        dir_d   = 1'b0;
      end else begin
        case (mode_sel)
          MODE_BOUNCE: begin
            if (!dir_q) begin
              if (at_hi) begin
                count_d = hi - ONE;
                dir_d   = 1'b1;
                turn_d  = 1'b1;
              end else begin
                count_d = count_q + ONE;
              end
            end else begin
              if (at_lo) begin
                count_d = lo + ONE;
                dir_d   = 1'b0;
                turn_d  = 1'b1;
              end else begin
                count_d = count_q - ONE;
              end
            end
          end
          MODE_WRAP_UP: begin
            dir_d = 1'b0;
            if (at_hi) begin
              count_d = lo;
              turn_d  = 1'b1;
            end else begin
              count_d = count_q + ONE;
            end
          end
          MODE_WRAP_DOWN: begin
            dir_d = 1'b1;
            if (at_lo) begin
              count_d = hi;
              turn_d  = 1'b1;
            end else begin
              count_d = count_q - ONE;
            end
          end
          default: begin
            count_d = count_q;
            dir_d   = dir_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      dir_q   <= 1'b0;
      turn_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      turn_q  <= turn_d;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign turn  = turn_q;

endmodule

// File: tb/tb_bounce_counter_cfg.sv
// Bench for bounce_counter_cfg: a WIDTH=4 and a WIDTH=8 instance, each tracked
// by a sequence model and checked every cycle, plus hand-computed checkpoints.
module tb_bounce_counter_cfg;

  // ---------------- clock / reset / stimulus signals ----------------
  logic       clk;
  logic       rst, en, load;
  logic [1:0] mode;
  logic [3:0] lo, hi, load_val;
  logic [3:0] count4;
  logic       dir4, turn4, cfg_err4;

  logic       rst8, en8, load8;
  logic [1:0] mode8;
  logic [7:0] lo8, hi8, load_val8;
  logic [7:0] count8;
  logic       dir8, turn8, cfg_err8;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bounce_counter_cfg #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .lo(lo), .hi(hi),
    .load(load), .load_val(load_val),
    .count(count4), .dir(dir4), .turn(turn4), .cfg_err(cfg_err4)
  );

  bounce_counter_cfg #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .mode(mode8), .lo(lo8), .hi(hi8),
    .load(load8), .load_val(load_val8),
    .count(count8), .dir(dir8), .turn(turn8), .cfg_err(cfg_err8)
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; outputs then reflect that edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- behavioural model ----------------
  // Sequence view: bounce reflects off the limits, wrap modes move cyclically
  // around the span lo..hi, everything else is a priority of overrides.
  function automatic void model_next(
    input int c, input int d, input int m, input int l, input int h,
    input bit e, input bit ld, input int lv, input bit rn,
    output int nc, output int nd, output int nt);
    int span, step, nxt;
    nc = c; nd = d; nt = 0;
    if (!rn) begin
      nc = 0; nd = 0;
      return;
    end
    if (ld) begin
      nc = (lv >= l && lv <= h) ? lv : l;
      return;
    end
    if (!e) return;
    if (l >= h || c < l || c > h) begin
      nc = l; nd = 0;
      return;
    end
    span = h - l + 1;
    case (m)
      0: begin
        step = d ? -1 : 1;
        nxt  = c + step;
        if (nxt > h || nxt < l) begin
          nc = c - step; nd = 1 - d; nt = 1;
        end else begin
          nc = nxt;
        end
      end
      1: begin
        nd = 0;
        nc = l + ((c - l + 1) % span);
        nt = (nc < c) ? 1 : 0;
      end
      2: begin
        nd = 1;
        nc = l + ((c - l - 1 + span) % span);
        nt = (nc > c) ? 1 : 0;
      end
      default: ;
    endcase
  endfunction

  int  m4_c, m4_d, m4_t, m8_c, m8_d, m8_t;
  bit  m4_valid = 0, m8_valid = 0;

  always @(posedge clk) begin
    int nc, nd, nt;
    model_next(m4_c, m4_d, int'(mode), int'(lo), int'(hi), en, load, int'(load_val), rst, nc, nd, nt);
    m4_c = nc; m4_d = nd; m4_t = nt;
    if (!rst) m4_valid = 1;
    model_next(m8_c, m8_d, int'(mode8), int'(lo8), int'(hi8), en8, load8, int'(load_val8), rst8, nc, nd, nt);
    m8_c = nc; m8_d = nd; m8_t = nt;
    if (!rst8) m8_valid = 1;
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    check("cfg_err4", cfg_err4, (lo >= hi));
    check("cfg_err8", cfg_err8, (lo8 >= hi8));
    if (m4_valid) begin
      check("model count4", count4, m4_c);
      check("model dir4", dir4, m4_d);
      check("model turn4", turn4, m4_t);
    end
    if (m8_valid) begin
      check("model count8", count8, m8_c);
      check("model dir8", dir8, m8_d);
      check("model turn8", turn8, m8_t);
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    rst = 0; en = 0; mode = 2'b00; lo = 4'd0; hi = 4'd15; load = 0; load_val = 4'd0;
    rst8 = 0; en8 = 0; mode8 = 2'b00; lo8 = 8'd0; hi8 = 8'd255; load8 = 0; load_val8 = 8'd0;

    // Reset state
    tick(); tick();
    check("reset count", count4, 0);
    check("reset dir", dir4, 0);
    check("reset turn", turn4, 0);

    // Full bounce 0..15..0, period 30
    rst = 1; en = 1;
    for (int i = 1; i <= 31; i++) begin
      tick();
      if (i == 15) check("bounce top", count4, 15);
      if (i == 16) begin
        check("bounce 15->14", count4, 14);
        check("bounce turn at 14", turn4, 1);
        check("bounce dir down", dir4, 1);
      end
      if (i == 17) check("bounce turn clears", turn4, 0);
      if (i == 30) check("bounce bottom", count4, 0);
      if (i == 31) begin
        check("bounce 0->1", count4, 1);
        check("bounce turn at 1", turn4, 1);
        check("bounce dir up", dir4, 0);
      end
    end

    // Wrap-up 3..6 then wrap-down
    mode = 2'b01; lo = 4'd3; hi = 4'd6; load = 1; load_val = 4'd3;
    tick(); check("wrap-up load", count4, 3);
    load = 0;
    tick(); check("wrap-up 4", count4, 4);
    tick(); check("wrap-up 5", count4, 5);
    tick(); check("wrap-up 6", count4, 6);
    check("wrap-up no turn at 6", turn4, 0);
    tick(); check("wrap-up 6->3", count4, 3);
    check("wrap-up turn", turn4, 1);
    tick(); check("wrap-up 4 again", count4, 4);
    mode = 2'b10;
    tick(); check("wrap-down 3", count4, 3);
    check("wrap-down dir", dir4, 1);
    tick(); check("wrap-down 3->6", count4, 6);
    check("wrap-down turn", turn4, 1);
    tick(); check("wrap-down 5", count4, 5);

    // Load while disabled, out-of-range load, load beats enable
    en = 0; load = 1; load_val = 4'd9; lo = 4'd0; hi = 4'd10;
    tick(); check("load 9 en=0", count4, 9);
    load = 0;
    tick(); check("hold at 9", count4, 9);
    load = 1; load_val = 4'd12;
    tick(); check("load oor -> lo", count4, 0);
    en = 1; load_val = 4'd7; mode = 2'b00;
    tick(); check("load beats en", count4, 7);
    load = 0;

    // Degenerate limits freeze at lo, then recovery
    lo = 4'd5; hi = 4'd5;
    #1 check("cfg_err set", cfg_err4, 1);
    tick(); check("cfg_err count", count4, 5);
    check("cfg_err turn", turn4, 0);
    tick(); check("cfg_err frozen", count4, 5);
    hi = 4'd8;
    #1 check("cfg_err clear", cfg_err4, 0);
    tick(); check("resume 6", count4, 6);
    tick(); check("resume 7", count4, 7);
    tick(); check("resume 8", count4, 8);
    tick(); check("resume bounce 7", count4, 7);
    check("resume turn", turn4, 1);

    // Limit shrink below count: held while disabled, resync when enabled
    lo = 4'd0; hi = 4'd15; mode = 2'b01; load = 1; load_val = 4'd10;
    tick(); load = 0;
    tick(); mode = 2'b00;
    tick(); check("pre-shrink 12", count4, 12);
    check("pre-shrink dir", dir4, 0);
    en = 0; hi = 4'd8;
    tick(); check("shrink en=0 holds", count4, 12);
    en = 1;
    tick(); check("shrink resync", count4, 0);
    check("shrink dir", dir4, 0);
    check("shrink no turn", turn4, 0);

    // Reset glitch between edges, then real reset with load pending
    hi = 4'd15;
    for (int i = 0; i < 7; i++) tick();
    check("pre-glitch 7", count4, 7);
    rst = 0; #5 rst = 1;
    tick(); check("glitch ignored", count4, 8);
    load = 1; load_val = 4'd3; rst = 0;
    tick(); check("reset over load", count4, 0);
    check("reset dir2", dir4, 0);
    check("reset turn2", turn4, 0);
    rst = 1; load = 0;

    // Hold mode
    tick(); tick(); tick();
    mode = 2'b11;
    tick(); check("hold 3", count4, 3);
    tick(); check("hold 3 again", count4, 3);
    mode = 2'b00;
    tick(); check("hold resume", count4, 4);

    // Full-range WIDTH=8 bounce, period 510
    rst8 = 1; en8 = 1;
    for (int i = 1; i <= 511; i++) begin
      tick();
      if (i == 255) check("w8 top", count8, 255);
      if (i == 256) begin
        check("w8 255->254", count8, 254);
        check("w8 turn top", turn8, 1);
      end
      if (i == 510) check("w8 bottom", count8, 0);
      if (i == 511) begin
        check("w8 0->1", count8, 1);
        check("w8 turn bottom", turn8, 1);
      end
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
